// File: rtl/fixed_to_float_pipe_if.sv
// Stream bundle between the CORDIC result path and the float converter.
// The master side produces fixed-point samples and consumes float results;
// the slave side is the converter itself.
interface fixed_to_float_pipe_if #(
   parameter int IN_W = 22
);
   logic                   in_valid;
   logic                   in_ready;
   logic signed [IN_W-1:0] in_data;
   logic                   out_valid;
   logic                   out_ready;
   logic [31:0]            out_data;
   logic                   out_zero;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_zero
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_zero
   );
endinterface

// File: rtl/fixed_to_float_pipe.sv
// Signed fixed-point (S1.FRAC_W) to IEEE-754 single converter.
// Three valid/ready stages: sign/magnitude, leading-one detect, normalize/pack.
// The conversion is exact because the magnitude never exceeds 24 significant bits.
module fixed_to_float_pipe #(
   parameter int IN_W   = 22,
   parameter int FRAC_W = 20
) (
   input logic                  clk,
   input logic                  reset,
   fixed_to_float_pipe_if.slave bus
);

   // MSB-first 4-to-2 priority encoder; all-zero input maps to 0.
   function automatic logic [1:0] enc4(input logic [3:0] x);
      if (x[3])      enc4 = 2'd3;
      else if (x[2]) enc4 = 2'd2;
      else if (x[1]) enc4 = 2'd1;
      else           enc4 = 2'd0;
   endfunction

   // Leading-one detect over 64 bits as a three-level tree of 4-to-2 encoders.
   // Returns {found, index[5:0]}.
   function automatic logic [6:0] lod64(input logic [63:0] x);
      logic [15:0]      v1;
      logic [15:0][1:0] i1;
      logic [3:0]       v2;
      logic [3:0][3:0]  i2;
      logic [1:0]       s;
      for (int g = 0; g < 16; g++) begin
         v1[g] = |x[4*g +: 4];
         i1[g] = enc4(x[4*g +: 4]);
      end
      for (int h = 0; h < 4; h++) begin
         v2[h] = |v1[4*h +: 4];
         s     = enc4(v1[4*h +: 4]);
         i2[h] = {s, i1[4*h + int'(s)]};
      end
      s     = enc4(v2);
      lod64 = {|v2, s, i2[s]};
   endfunction

   // Build the float word: biased exponent from the leading-one position,
   // fraction from the magnitude left-aligned so the hidden one falls off.
   function automatic logic [31:0] pack(input logic            s,
                                        input logic            z,
                                        input logic [5:0]      p,
                                        input logic [IN_W-1:0] m);
      logic [7:0]  e;
      logic [22:0] f;
      e = 8'(127 - FRAC_W + int'(p));
      f = 23'((48'(m) << 23) >> p);
      if (z) pack = 32'h0000_0000;
      else   pack = {s, e, f};
   endfunction

   logic signed [IN_W-1:0] din;
   logic                   in_ready_int;
   logic                   acc;
   logic                   ld_p0, ld_p1, ld_p2;
   logic                   vld_p0, vld_p1, vld_p2;
   logic                   sign_p0;
   logic [IN_W-1:0]        mag_p0;
   logic                   sign_p1;
   logic                   zero_p1;
   logic [5:0]             pos_p1;
   logic [IN_W-1:0]        mag_p1;
   logic [6:0]             lod_p0;
   logic [31:0]            data_p2;
   logic                   zero_p2;

   assign din    = bus.in_data;
   assign lod_p0 = lod64(64'(mag_p0));

   // A stage loads when empty or when its occupant moves on this edge.
   assign ld_p2        = !vld_p2 || bus.out_ready;
   assign ld_p1        = !vld_p1 || ld_p2;
   assign ld_p0        = !vld_p0 || ld_p1;
   assign in_ready_int = !reset && ld_p0;
   assign acc          = bus.in_valid && in_ready_int;

   // Stage valid bits; reset discards everything in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_p0 <= 1'b0;
         vld_p1 <= 1'b0;
         vld_p2 <= 1'b0;
      end else begin
         if (ld_p0) vld_p0 <= acc;
         if (ld_p1) vld_p1 <= vld_p0;
         if (ld_p2) vld_p2 <= vld_p1;
      end
   end

   // S1: split sign and magnitude; the most negative input gives MSB-only.
   always_ff @(posedge clk) begin
      if (acc) begin
         sign_p0 <= din[IN_W-1];
         mag_p0  <= din[IN_W-1] ? $unsigned(-din) : $unsigned(din);
      end
   end

   // S2: locate the leading one and flag a zero magnitude.
   always_ff @(posedge clk) begin
      if (ld_p1 && vld_p0) begin
         sign_p1 <= sign_p0;
         mag_p1  <= mag_p0;
         pos_p1  <= lod_p0[5:0];
         zero_p1 <= !lod_p0[6];
      end
   end

   // S3: normalize and pack; cleared on reset so the output reads zero until the first result.
   always_ff @(posedge clk) begin
      if (reset) begin
         data_p2 <= 32'h0000_0000;
         zero_p2 <= 1'b0;
      end else if (ld_p2 && vld_p1) begin
         data_p2 <= pack(sign_p1, zero_p1, pos_p1, mag_p1);
         zero_p2 <= zero_p1;
      end
   end

   assign bus.in_ready  = in_ready_int;
   assign bus.out_valid = vld_p2;
   assign bus.out_data  = data_p2;
   assign bus.out_zero  = zero_p2;

endmodule
